output_layer_sequencer: RTL and testbench

- Initiator-side controller for the `node` neuron handshake (start/ready/out).
- Time-multiplexes one shared `node` instance across all output neurons of a layer: fetches each neuron's weights and bias from synchronous-read memories, drives `node_start`, waits for `node_ready`, then captures `node_out`.
- Produces the full output vector plus the argmax class index (recognised letter) for the layer.
- Sits between the layer weight/bias memories and the `node` instance. The activation vector `in` goes straight to the node and is not routed through this block.

---
 rtl/mlp_pkg.sv | 15 +
 rtl/argmax_tracker.sv | 35 +++
 rtl/output_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_output_layer_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and default sizes for the MLP output layer.
// Latency: none, declarations only.
// Backpressure: n/a.
package mlp_pkg;

  localparam int BITS        = 16;
  localparam int FRAC_BITS   = 11;
  localparam int OUT_IN_SIZE = 50;
  localparam int OUT_SIZE    = 10;

  typedef logic signed [BITS-1:0] fixed_t;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CLEAR, DONE} seq_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Streaming signed maximum with its index; ties keep the earliest index.
// Latency: max_idx reflects an update one cycle after upd_vld.
// Backpressure: none, accepts an update every cycle.
module argmax_tracker
  import mlp_pkg::*;
#(
  parameter int bits     = BITS,
  parameter int idx_bits = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       upd_vld,
  input  logic signed [bits-1:0]     upd_dat,
  input  logic        [idx_bits-1:0] upd_idx,
  output logic        [idx_bits-1:0] max_idx
);

  logic                   max_vld;
  logic signed [bits-1:0] max_dat;

  // The first sample after clear always seeds the running maximum.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      max_vld <= 1'b0;
      max_dat <= '0;
      max_idx <= '0;
    end else if (upd_vld && (!max_vld || (upd_dat > max_dat))) begin
      max_vld <= 1'b1;
      max_dat <= upd_dat;
      max_idx <= upd_idx;
    end
  end

endmodule

// File: rtl/output_layer_sequencer.sv
// Time-multiplexes one node across a layer: fetch weights/bias, run node, capture, argmax.
// Latency: per neuron (in_size+1) + node latency + 1 + clear wait; layer is the sum.
// Backpressure: node_start held until node_ready; start ignored unless IDLE or DONE.
module output_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int bits            = BITS,
  parameter int fractional_bits = FRAC_BITS,
  parameter int in_size         = OUT_IN_SIZE,
  parameter int out_size        = OUT_SIZE,
  localparam int WA             = $clog2(in_size*out_size),
  localparam int NA             = $clog2(out_size)
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic                                    start,
  output logic                                    ready,
  output logic signed [out_size-1:0][bits-1:0]    results,
  output logic        [NA-1:0]                    class_out,
  output logic        [WA-1:0]                    w_addr,
  input  logic signed [bits-1:0]                  w_data,
  output logic        [NA-1:0]                    b_addr,
  input  logic signed [bits-1:0]                  b_data,
  output logic                                    node_start,
  output logic signed [in_size-1:0][bits-1:0]     node_weights,
  output logic signed [bits-1:0]                  node_bias,
  input  logic                                    node_ready,
  input  logic signed [bits-1:0]                  node_out
);

  localparam int KW = $clog2(in_size+1);
  localparam logic [KW-1:0] K_LAST      = KW'(in_size);
  localparam logic [KW-1:0] K_ADDR_LAST = KW'(in_size-1);
  localparam logic [NA-1:0] N_LAST      = NA'(out_size-1);

  // The fixed-point format is passed through untouched; nothing here scales by it.
  if (fractional_bits < 0 || fractional_bits >= bits) begin : g_bad_fixed_format
  end

  seq_state_t    state, state_nxt;
  logic [NA-1:0] n;
  logic [KW-1:0] k;
  logic          layer_go;
  logic          capture;
  logic [NA-1:0] best_idx;

  assign b_addr   = n;
  assign layer_go = ((state == IDLE) || (state == DONE)) && start;
  assign capture  = (state == RUN) && node_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)       state_nxt = LOAD;
      LOAD:       if (k == K_LAST) state_nxt = RUN;
      RUN:        if (node_ready)  state_nxt = CLEAR;
      CLEAR:      if (!node_ready) state_nxt = (n == N_LAST) ? DONE : LOAD;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready        <= 1'b0;
      node_start   <= 1'b0;
      w_addr       <= '0;
      n            <= '0;
      k            <= '0;
      class_out    <= '0;
      results      <= '0;
      node_weights <= '0;
      node_bias    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (layer_go) begin
            ready  <= 1'b0;
            n      <= '0;
            k      <= '0;
            w_addr <= '0;
          end
        end
        LOAD: begin
          // Read data lags the address by one cycle, so slot k-1 lands while k is issued.
          if (k != '0)        node_weights[k - 1'b1] <= w_data;
          if (k == KW'(1))    node_bias <= b_data;
          if (k < K_ADDR_LAST) w_addr <= w_addr + 1'b1;
          if (k == K_LAST)    node_start <= 1'b1;
          else                k <= k + 1'b1;
        end
        RUN: begin
          if (node_ready) begin
            results[n] <= node_out;
            node_start <= 1'b0;
          end
        end
        CLEAR: begin
          if (!node_ready) begin
            if (n == N_LAST) begin
              ready     <= 1'b1;
              class_out <= best_idx;
            end else begin
              n      <= n + 1'b1;
              k      <= '0;
              // Neuron n+1's weights start right after neuron n's last word.
              w_addr <= w_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  argmax_tracker #(
    .bits     (bits),
    .idx_bits (NA)
  ) u_argmax (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (layer_go),
    .upd_vld  (capture),
    .upd_dat  (node_out),
    .upd_idx  (n),
    .max_idx  (best_idx)
  );

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Scoreboard bench for output_layer_sequencer with a stub node and sync-read memories.
// Latency: n/a. Backpressure: stub node delays and holds node_ready.
module tb_output_layer_sequencer;
  import mlp_pkg::*;

  typedef struct packed {
    logic [9:0][15:0] res;
    logic [3:0]       cls;
  } layer_exp_t;

  typedef struct packed {
    logic [15:0] bias;
    logic [8:0]  wbase;
  } cap_exp_t;

  logic                     clock = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start = 1'b0;
  logic                     ready;
  logic signed [9:0][15:0]  results;
  logic [3:0]               class_out;
  logic [8:0]               w_addr;
  logic signed [15:0]       w_data;
  logic [3:0]               b_addr;
  logic signed [15:0]       b_data;
  logic                     node_start;
  logic signed [49:0][15:0] node_weights;
  logic signed [15:0]       node_bias;
  logic                     node_ready;
  logic signed [15:0]       node_out;

  logic [15:0] bias_mem [10];
  int          node_delay = 5;
  int          hold_extra = 0;
  int          cnt, hcnt;

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  layer_exp_t lay_q[$];
  cap_exp_t   cap_q[$];

  output_layer_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .ready        (ready),
    .results      (results),
    .class_out    (class_out),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .node_start   (node_start),
    .node_weights (node_weights),
    .node_bias    (node_bias),
    .node_ready   (node_ready),
    .node_out     (node_out)
  );

  always #5 clock = ~clock;

  // Memories: weight word equals its address; biases from a table.
  always_ff @(posedge clock) begin
    w_data <= 16'(w_addr);
    b_data <= bias_mem[b_addr];
  end

  // Stub node: result = bias, ready after node_delay cycles, cleared hold_extra cycles after start drops.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      node_ready <= 1'b0;
      node_out   <= '0;
      cnt        <= 0;
      hcnt       <= 0;
    end else if (node_start && !node_ready) begin
      if (cnt >= node_delay - 1) begin
        node_ready <= 1'b1;
        node_out   <= node_bias;
        cnt        <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else if (!node_start && node_ready) begin
      if (hcnt >= hold_extra) begin
        node_ready <= 1'b0;
        hcnt       <= 0;
      end else begin
        hcnt <= hcnt + 1;
      end
    end
  end

  function automatic logic [31:0] u16(input logic [15:0] v);
    return {16'h0, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: per-capture weight/bias checks, per-layer result checks, handshake rules.
  initial begin : monitor
    logic       st_q, capq, rdy_q;
    int         caps, bad_k;
    cap_exp_t   ce;
    layer_exp_t le;
    st_q = 1'b0; capq = 1'b0; rdy_q = 1'b0; caps = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        st_q = 1'b0; capq = 1'b0; rdy_q = 1'b0;
      end else begin
        if (node_start && node_ready) begin
          caps++;
          if (cap_q.size() == 0) begin
            check("unexpected_capture", 32'd1, 32'd0);
          end else begin
            ce = cap_q.pop_front();
            check("node_bias", u16(node_bias), u16(ce.bias));
            bad_k = 49;
            for (int kk = 0; kk < 50; kk++)
              if (node_weights[kk] !== 16'(ce.wbase + 9'(kk)) && bad_k == 49) bad_k = kk;
            check($sformatf("node_weights[%0d]", bad_k), u16(node_weights[bad_k]),
                  u16(16'(ce.wbase + 9'(bad_k))));
          end
        end
        if (st_q && !node_start && !capq) viol++;
        if (!st_q && node_start && node_ready) viol++;
        st_q = node_start;
        capq = node_start && node_ready;
        if (ready && !rdy_q) begin
          if (lay_q.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
          end else begin
            le = lay_q.pop_front();
            for (int i = 0; i < 10; i++)
              check($sformatf("results[%0d]", i), u16(results[i]), u16(le.res[i]));
            check("class_out", 32'(class_out), 32'(le.cls));
            check("captures", 32'(caps), 32'd10);
          end
          caps = 0;
        end
        rdy_q = ready;
      end
    end
  end

  task automatic run_layer(input string tag, input logic [15:0] b [10], input int delay,
                           input int hold, input logic [3:0] exp_cls, input int exp_cyc,
                           input int p1, input int p2);
    layer_exp_t le;
    cap_exp_t   ce;
    int         cyc;
    node_delay = delay;
    hold_extra = hold;
    for (int i = 0; i < 10; i++) begin
      bias_mem[i] = b[i];
      le.res[i]   = b[i];
      ce.bias     = b[i];
      ce.wbase    = 9'(i * 50);
      cap_q.push_back(ce);
    end
    le.cls = exp_cls;
    lay_q.push_back(le);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check({tag, "_ready_drop"}, {31'h0, ready}, 32'h0);
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clock);
      cyc++;
      #1 start = (cyc == p1) || (cyc == p2);
      if (ready) break;
    end
    start = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [15:0] ba [10];
    logic [15:0] bb [10];
    logic [15:0] bd [10];
    logic        seen, ns_seen;
    logic [8:0]  wmax;

    ba = '{16'h0010, 16'hFFE0, 16'h0300, 16'h0005, 16'h0000,
           16'h0300, 16'hFFFF, 16'h0007, 16'h0008, 16'h0009};
    bb = '{16'hFFFB, 16'hFF00, 16'hFFFD, 16'h8001, 16'hFFFE,
           16'hFFF7, 16'h8000, 16'hFFFC, 16'hFFFA, 16'hFFFF};
    bd = '{default: 16'h0123};
    for (int i = 0; i < 10; i++) bias_mem[i] = '0;

    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",        {31'h0, ready},                 32'h0);
    check("rst_node_start",   {31'h0, node_start},            32'h0);
    check("rst_w_addr",       32'(w_addr),                    32'h0);
    check("rst_b_addr",       32'(b_addr),                    32'h0);
    check("rst_class_out",    32'(class_out),                 32'h0);
    check("rst_results",      {31'h0, results == '0},         32'h1);
    check("rst_node_weights", {31'h0, node_weights == '0},    32'h1);
    check("rst_node_bias",    u16(node_bias),                 32'h0);
    check("rst_state",        32'(dut.state),                 32'(IDLE));
    reset_n = 1'b1;

    // Ties at 0x300 resolve to index 2.
    run_layer("layer_a", ba, 5, 0, 4'd2, 590, 0, 0);
    // Restart from DONE, slow node with ready held after start drops, start pulsed mid-LOAD.
    run_layer("layer_b", bb, 40, 3, 4'd9, 970, 10, 311);

    // Reset while the node is being driven.
    node_delay = 40;
    hold_extra = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("midrst_ready_drop", {31'h0, ready}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clock);
      #1 if (node_start) seen = 1'b1;
    end
    check("midrst_run_reached", {31'h0, seen}, 32'h1);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    check("midrst_node_start", {31'h0, node_start},    32'h0);
    check("midrst_ready",      {31'h0, ready},         32'h0);
    check("midrst_class_out",  32'(class_out),         32'h0);
    check("midrst_results",    {31'h0, results == '0}, 32'h1);
    check("midrst_state",      32'(dut.state),         32'(IDLE));
    wmax = '0;
    ns_seen = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (w_addr > wmax) wmax = w_addr;
      if (node_start) ns_seen = 1'b1;
    end
    check("midrst_w_addr_quiet",     32'(wmax),          32'h0);
    check("midrst_node_start_quiet", {31'h0, ns_seen},   32'h0);

    // All-equal results keep index 0.
    run_layer("layer_d", bd, 5, 0, 4'd0, 590, 0, 0);

    repeat (5) @(posedge clock);
    check("cap_q_drained",   32'(cap_q.size()), 32'h0);
    check("lay_q_drained",   32'(lay_q.size()), 32'h0);
    check("handshake_rules", 32'(viol),         32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
